alu_seq: RTL and testbench

- Parametrised, clocked successor to the team's 4-bit combinational ALU.
- Operand width is set by WIDTH; the opcode set grows to 8 operations, including a multi-cycle unsigned multiply.
- Operations are accepted and results delivered through valid/ready handshakes on both sides, and the result is registered.
- Sits between an operand source (sequencer/testbench) and a result consumer.

---
 rtl/alu_seq.sv | 193 +++++++++++++++++++
 tb/tb_alu_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential WIDTH-bit ALU with handshakes and a shift-add multiplier.
// Optional status flags {zero, carry, overflow} when ALU_FLAGS_EN is defined.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         code,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef ALU_FLAGS_EN
  output logic [2:0]         flags,
`endif
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] LP_W = WIDTH'(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2*WIDTH-1:0] r_result;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;

  logic               w_accept;
  logic               w_mul_last;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_shl;
  logic [WIDTH-1:0]   w_shr;
  logic [2*WIDTH-1:0] w_alu_res;
  logic [2*WIDTH-1:0] w_acc_next;

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign result     = r_result;
  assign w_accept   = in_valid && (r_state == S_IDLE);
  assign w_mul_last = (r_state == S_BUSY) &&
                      (r_cnt == CW'(WIDTH - 1));

  // single-cycle operations, evaluated straight off the inputs
  always_comb begin
    w_sum     = {1'b0, a} + {1'b0, b};
    w_diff    = {1'b0, a} - {1'b0, b};
    w_shl     = (b >= LP_W) ? '0 : (a << b);
    w_shr     = (b >= LP_W) ? '0 : (a >> b);
    w_alu_res = '0;
    unique case (code)
      OP_ADD: w_alu_res = {{(WIDTH-1){1'b0}}, w_sum};
      OP_SUB: w_alu_res = {{(WIDTH-1){1'b0}}, w_diff};
      OP_AND: w_alu_res = {{WIDTH{1'b0}}, a & b};
      OP_OR:  w_alu_res = {{WIDTH{1'b0}}, a | b};
      OP_XOR: w_alu_res = {{WIDTH{1'b0}}, a ^ b};
      OP_SHL: w_alu_res = {{WIDTH{1'b0}}, w_shl};
      OP_SHR: w_alu_res = {{WIDTH{1'b0}}, w_shr};
      OP_MUL: w_alu_res = '0;
      default: w_alu_res = '0;
    endcase
  end

  // partial-product accumulate for the current multiplier bit
  always_comb begin
    w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  end

  // state register; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state: MUL detours through BUSY, everything else goes to DONE
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_next = (code == OP_MUL) ? S_BUSY : S_DONE;
        end
      end
      S_BUSY: begin
        if (w_mul_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // multiplier datapath: one bit of b per BUSY cycle, LSB first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept && (code == OP_MUL)) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_BUSY) begin
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_acc    <= w_acc_next;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  // result register, held through DONE until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
    end else if (w_accept && (code != OP_MUL)) begin
      r_result <= w_alu_res;
    end else if (w_mul_last) begin
      r_result <= w_acc_next;
    end
  end

`ifdef ALU_FLAGS_EN
  logic [2:0] r_flags;
  logic [2:0] w_alu_flags;
  logic [2:0] w_mul_flags;
  logic       w_add_ovf;
  logic       w_sub_ovf;

  assign flags = r_flags;

  // {zero, carry, overflow} for the single-cycle ops
  always_comb begin
    w_add_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                (w_sum[WIDTH-1] != a[WIDTH-1]);
    w_sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                (w_diff[WIDTH-1] != a[WIDTH-1]);
    w_alu_flags = {(w_alu_res == '0), 2'b00};
    unique case (code)
      OP_ADD: w_alu_flags[1:0] = {w_sum[WIDTH], w_add_ovf};
      OP_SUB: w_alu_flags[1:0] = {w_diff[WIDTH], w_sub_ovf};
      default: w_alu_flags[1:0] = 2'b00;
    endcase
  end

  // MUL overflow means the product does not fit in WIDTH bits
  always_comb begin
    w_mul_flags = {(w_acc_next == '0), 1'b0,
                   (w_acc_next[2*WIDTH-1:WIDTH] != '0)};
  end

  // flags travel with the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= '0;
    end else if (w_accept && (code != OP_MUL)) begin
      r_flags <= w_alu_flags;
    end else if (w_mul_last) begin
      r_flags <= w_mul_flags;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq (WIDTH=4) with a scoreboard.
// Flag checks are active when built with ALU_FLAGS_EN.
module tb_alu_seq;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2:0]     code = '0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] result;
`ifdef ALU_FLAGS_EN
  logic [2:0]     flags;
`endif

  int errors = 0;
  int checks = 0;
  logic [2*W+2:0] q[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .code(code),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef ALU_FLAGS_EN
    .flags(flags),
`endif
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: a handshake completes on the next rising edge
  always begin
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      logic [2*W+2:0] e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", result);
      end else begin
        e = q.pop_front();
        if (result !== e[2*W-1:0]) begin
          errors++;
          $display("FAIL result: got %0h expected %0h",
                   result, e[2*W-1:0]);
        end
`ifdef ALU_FLAGS_EN
        checks++;
        if (flags !== e[2*W+2:2*W]) begin
          errors++;
          $display("FAIL flags: got %b expected %b",
                   flags, e[2*W+2:2*W]);
        end
`endif
      end
    end
  end

  task automatic send(input logic [2:0] c, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic [2*W-1:0] r,
                      input logic [2:0] f, input bit push);
    int t = 0;
    while (!in_ready && t < 64) begin
      step();
      t++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    code = c;
    a = x;
    b = y;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    if (push) q.push_back({f, r});
  endtask

  task automatic run(input string nm, input logic [2:0] c,
                     input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [2*W-1:0] r, input logic [2:0] f,
                     input int lat_exp);
    int n = 0;
    int lat = 0;
    send(c, x, y, r, f, 1'b1);
    while (!in_ready && n < 64) begin
      if (out_valid && lat == 0) lat = n + 1;
      n++;
      step();
    end
    chk({nm, "_latency"}, 32'(lat), 32'(lat_exp));
    chk({nm, "_busy"}, 32'(n), 32'(lat_exp));
  endtask

  initial begin
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    step();
    rst = 1'b0;
    step();

    run("add_0_15", 3'd0, 4'd0, 4'd15, 8'h0F, 3'b000, 1);
    run("add_7_13", 3'd0, 4'd7, 4'd13, 8'h14, 3'b010, 1);
    run("sub_1_3", 3'd1, 4'd1, 4'd3, 8'h1E, 3'b010, 1);
    run("and_9_3", 3'd2, 4'd9, 4'd3, 8'h01, 3'b000, 1);
    run("shl_3_5", 3'd5, 4'd3, 4'd5, 8'h00, 3'b100, 1);
    run("mul_9_3", 3'd7, 4'd9, 4'd3, 8'h1B, 3'b001, 5);
    run("mul_f_f", 3'd7, 4'd15, 4'd15, 8'hE1, 3'b001, 5);
    run("or_a_5", 3'd3, 4'hA, 4'h5, 8'h0F, 3'b000, 1);
    run("shr_12_2", 3'd6, 4'd12, 4'd2, 8'h03, 3'b000, 1);
    run("shr_8_4", 3'd6, 4'd8, 4'd4, 8'h00, 3'b100, 1);
    run("sub_5_5", 3'd1, 4'd5, 4'd5, 8'h00, 3'b100, 1);
    run("add_7_1", 3'd0, 4'd7, 4'd1, 8'h08, 3'b001, 1);
    run("sub_8_1", 3'd1, 4'd8, 4'd1, 8'h07, 3'b001, 1);
    run("add_f_1", 3'd0, 4'd15, 4'd1, 8'h10, 3'b010, 1);
    run("mul_0_d", 3'd7, 4'd0, 4'd13, 8'h00, 3'b100, 5);
    run("shl_1_3", 3'd5, 4'd1, 4'd3, 8'h08, 3'b000, 1);

    // backpressure with in_valid toggling
    out_ready = 1'b0;
    send(3'd4, 4'd5, 4'd3, 8'h06, 3'b000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      in_valid = ~in_valid;
      code = 3'd0;
      a = 4'd1;
      b = 4'd1;
      step();
      chk("bp_result", 32'(result), 32'h06);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);

    // reset during BUSY cycle 2 of a MUL
    send(3'd7, 4'd9, 4'd3, 8'h1B, 3'b001, 1'b0);
    step();
    chk("abort_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_output", 32'(out_valid), 32'd0);
    end
    run("add_2_2", 3'd0, 4'd2, 4'd2, 8'h04, 3'b000, 1);

    repeat (3) step();
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
